wb_arbiter: RTL and testbench

//  Write-back arbiter: the writer end of the register-file write port (reg_wen/reg_waddr/reg_wdata).

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_pkg
//  Description : Shared constants and types for the write-back arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int         XLEN     = 32;
    localparam int         AW       = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Which source drives the register write port this cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EX   = 2'd1,
        SRC_LU   = 2'd2
    } wb_src_e;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Small synchronous FIFO holding deferred LU results
//                ({addr, data}); head is visible combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 37,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; the caller guarantees no push when full / pop when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Merges single-cycle EX results and long-latency LU results
//                onto one registered register-file write port, and tracks
//                registers with an outstanding LU write for ID stalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter  int DEPTH = 2,
    parameter  int XLEN  = wb_arbiter_pkg::XLEN,
    parameter  int AW    = wb_arbiter_pkg::AW,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_wen_i,
    input  logic [AW-1:0]   ex_waddr_i,
    input  logic [XLEN-1:0] ex_wdata_i,
    input  logic            lu_valid_i,
    output logic            lu_ready_o,
    input  logic [AW-1:0]   lu_waddr_i,
    input  logic [XLEN-1:0] lu_wdata_i,
    input  logic            iss_valid_i,
    input  logic [AW-1:0]   iss_rd_i,
    input  logic [AW-1:0]   chk_rs1_i,
    input  logic [AW-1:0]   chk_rs2_i,
    output logic            busy_o,
    output logic            reg_wen_o,
    output logic [AW-1:0]   reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic [CW-1:0]   fifo_cnt_o
);
    import wb_arbiter_pkg::*;

    localparam logic [AW-1:0] C_X0 = AW'(REG_ZERO);

    logic                  r_live;        // low during reset, high from the first edge after
    logic [2**AW-1:0]      r_busy;
    logic [2**AW-1:0]      w_busy_next;
    wb_src_e               w_src;
    logic                  w_ex_act;
    logic                  w_lu_xfer;
    logic                  w_lu_nz;
    logic                  w_fifo_empty;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [AW+XLEN-1:0]    w_head;
    logic [AW-1:0]         w_sel_addr;
    logic [XLEN-1:0]       w_sel_data;
    logic [CW-1:0]         w_cnt;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AW + XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({lu_waddr_i, lu_wdata_i}),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_cnt)
    );

    // No pass-through when full: ready depends only on stored occupancy
    assign lu_ready_o = r_live && (w_cnt < CW'(DEPTH));
    assign fifo_cnt_o = w_cnt;
    // Bit 0 is never set, so x0 can never report busy
    assign busy_o     = r_busy[chk_rs1_i] | r_busy[chk_rs2_i];

    // Source selection: EX beats the FIFO head, which beats a direct LU bypass
    always_comb begin
        w_ex_act     = ex_wen_i && (ex_waddr_i != C_X0);
        w_lu_xfer    = lu_valid_i && lu_ready_o;
        w_lu_nz      = (lu_waddr_i != C_X0);
        w_fifo_empty = (w_cnt == '0);
        // LU results to x0 complete the handshake but are simply dropped
        w_bypass     = w_lu_xfer && w_lu_nz && w_fifo_empty && !w_ex_act;
        w_push       = w_lu_xfer && w_lu_nz && !w_bypass;
        w_pop        = !w_ex_act && !w_fifo_empty;
        w_src        = SRC_NONE;
        w_sel_addr   = '0;
        w_sel_data   = '0;
        if (w_ex_act) begin
            w_src      = SRC_EX;
            w_sel_addr = ex_waddr_i;
            w_sel_data = ex_wdata_i;
        end else if (w_pop) begin
            w_src      = SRC_LU;
            w_sel_addr = w_head[AW+XLEN-1:XLEN];
            w_sel_data = w_head[XLEN-1:0];
        end else if (w_bypass) begin
            w_src      = SRC_LU;
            w_sel_addr = lu_waddr_i;
            w_sel_data = lu_wdata_i;
        end
    end

    // Scoreboard update: clear on LU write-back, then set on issue so set wins
    always_comb begin
        w_busy_next = r_busy;
        if (w_src == SRC_LU) begin
            w_busy_next[w_sel_addr] = 1'b0;
        end
        if (iss_valid_i && (iss_rd_i != C_X0)) begin
            w_busy_next[iss_rd_i] = 1'b1;
        end
    end

    // Registered write port, scoreboard and out-of-reset flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live      <= 1'b0;
            r_busy      <= '0;
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            r_live      <= 1'b1;
            r_busy      <= w_busy_next;
            reg_wen_o   <= (w_src != SRC_NONE);
            reg_waddr_o <= w_sel_addr;
            reg_wdata_o <= w_sel_data;
        end
    end

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter; expected register writes
//                are queued at stimulus time and matched by a write monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            rst;
    logic            ex_wen;
    logic [AW-1:0]   ex_waddr;
    logic [XLEN-1:0] ex_wdata;
    logic            lu_valid;
    logic            lu_ready;
    logic [AW-1:0]   lu_waddr;
    logic [XLEN-1:0] lu_wdata;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic            busy;
    logic            reg_wen;
    logic [AW-1:0]   reg_waddr;
    logic [XLEN-1:0] reg_wdata;
    logic [CW-1:0]   fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+XLEN-1:0] exp_q[$];

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_wen_i    (ex_wen),
        .ex_waddr_i  (ex_waddr),
        .ex_wdata_i  (ex_wdata),
        .lu_valid_i  (lu_valid),
        .lu_ready_o  (lu_ready),
        .lu_waddr_i  (lu_waddr),
        .lu_wdata_i  (lu_wdata),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .chk_rs1_i   (chk_rs1),
        .chk_rs2_i   (chk_rs2),
        .busy_o      (busy),
        .reg_wen_o   (reg_wen),
        .reg_waddr_o (reg_waddr),
        .reg_wdata_o (reg_wdata),
        .fifo_cnt_o  (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_wen = 1'b0; ex_waddr = '0; ex_wdata = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Write monitor: every observed write must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && reg_wen) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_write", 64'(reg_waddr), 64'hFFFF);
            end else begin
                logic [AW+XLEN-1:0] e;
                e = exp_q.pop_front();
                check_val("wr_addr", 64'(reg_waddr), 64'(e[AW+XLEN-1:XLEN]));
                check_val("wr_data", 64'(reg_wdata), 64'(e[XLEN-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        chk_rs1 = '0; chk_rs2 = '0;
        #2;
        check_val("rst_wen",   64'(reg_wen),   0);
        check_val("rst_waddr", 64'(reg_waddr), 0);
        check_val("rst_wdata", 64'(reg_wdata), 0);
        check_val("rst_ready", 64'(lu_ready),  0);
        check_val("rst_cnt",   64'(fifo_cnt),  0);
        check_val("rst_busy",  64'(busy),      0);
        step(); step();
        rst = 1'b0;
        #1;
        check_val("ready_before_edge", 64'(lu_ready), 0);
        step();
        check_val("ready_after_edge", 64'(lu_ready), 1);

        // EX only, then EX to x0
        ex_wen = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h11; expect_wr(5'd5, 32'h11);
        step();
        check_val("ex_wen", 64'(reg_wen), 1);
        check_val("ex_addr", 64'(reg_waddr), 5);
        ex_waddr = 5'd0; ex_wdata = 32'h22;
        step();
        check_val("ex_x0_wen", 64'(reg_wen), 0);
        clear_inputs();

        // LU bypass with scoreboard
        iss_valid = 1'b1; iss_rd = 5'd7; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        step();
        clear_inputs();
        #1;
        check_val("busy_set", 64'(busy), 1);
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'hAB; expect_wr(5'd7, 32'hAB);
        step();
        clear_inputs();
        #1;
        check_val("byp_wen", 64'(reg_wen), 1);
        check_val("byp_cnt", 64'(fifo_cnt), 0);
        check_val("busy_clr", 64'(busy), 0);

        // EX / LU conflict
        ex_wen = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h33;
        lu_valid = 1'b1; lu_waddr = 5'd4; lu_wdata = 32'h44;
        expect_wr(5'd3, 32'h33); expect_wr(5'd4, 32'h44);
        step();
        clear_inputs();
        check_val("conf_addr1", 64'(reg_waddr), 3);
        check_val("conf_cnt1", 64'(fifo_cnt), 1);
        step();
        check_val("conf_addr2", 64'(reg_waddr), 4);
        check_val("conf_cnt2", 64'(fifo_cnt), 0);
        step();
        check_val("conf_idle", 64'(reg_wen), 0);

        // Full FIFO under continuous EX, then drain in order
        for (int i = 0; i < 3; i++) begin
            ex_wen = 1'b1; ex_waddr = AW'(10 + i); ex_wdata = 32'(16'h0101 * (10 + i));
            expect_wr(AW'(10 + i), 32'(16'h0101 * (10 + i)));
            lu_valid = 1'b1; lu_waddr = AW'(20 + i); lu_wdata = 32'(16'h0101 * (20 + i));
            step();
        end
        check_val("full_cnt", 64'(fifo_cnt), 2);
        check_val("full_ready", 64'(lu_ready), 0);
        ex_wen = 1'b0;                       // lu 22 still offered
        expect_wr(5'd20, 32'(16'h0101 * 20));
        step();
        check_val("drain_cnt1", 64'(fifo_cnt), 1);
        check_val("drain_ready", 64'(lu_ready), 1);
        expect_wr(5'd21, 32'(16'h0101 * 21)); // pop 21 while 22 is pushed
        step();
        lu_valid = 1'b0;
        check_val("pushpop_cnt", 64'(fifo_cnt), 1);
        expect_wr(5'd22, 32'(16'h0101 * 22));
        step();
        check_val("drain_cnt0", 64'(fifo_cnt), 0);
        clear_inputs();

        // Set wins over clear on the same rd
        iss_valid = 1'b1; iss_rd = 5'd9; chk_rs1 = 5'd0; chk_rs2 = 5'd9;
        step();
        clear_inputs();
        ex_wen = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h1111; expect_wr(5'd1, 32'h1111);
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h9999;
        step();
        clear_inputs();
        iss_valid = 1'b1; iss_rd = 5'd9; expect_wr(5'd9, 32'h9999);
        step();
        clear_inputs();
        #1;
        check_val("set_wins", 64'(busy), 1);
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h9A9A; expect_wr(5'd9, 32'h9A9A);
        step();
        clear_inputs();
        #1;
        check_val("busy9_clr", 64'(busy), 0);

        // LU result to x0 is accepted and dropped
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hDEAD;
        step();
        clear_inputs();
        check_val("lu_x0_wen", 64'(reg_wen), 0);
        check_val("lu_x0_cnt", 64'(fifo_cnt), 0);

        // Reset while work is in flight
        iss_valid = 1'b1; iss_rd = 5'd7; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        step();
        clear_inputs();
        ex_wen = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'h2; expect_wr(5'd2, 32'h2);
        lu_valid = 1'b1; lu_waddr = 5'd20; lu_wdata = 32'h20;
        step();
        ex_waddr = 5'd3; ex_wdata = 32'h3; expect_wr(5'd3, 32'h3);
        lu_waddr = 5'd21; lu_wdata = 32'h21;
        step();
        clear_inputs();
        check_val("pre_rst_cnt", 64'(fifo_cnt), 2);
        check_val("pre_rst_busy", 64'(busy), 1);
        #5;
        rst = 1'b1;
        #1;
        check_val("mid_rst_wen", 64'(reg_wen), 0);
        check_val("mid_rst_waddr", 64'(reg_waddr), 0);
        check_val("mid_rst_wdata", 64'(reg_wdata), 0);
        check_val("mid_rst_cnt", 64'(fifo_cnt), 0);
        check_val("mid_rst_ready", 64'(lu_ready), 0);
        check_val("mid_rst_busy", 64'(busy), 0);
        step();
        rst = 1'b0;
        step();
        check_val("post_rst_ready", 64'(lu_ready), 1);
        ex_wen = 1'b1; ex_waddr = 5'd6; ex_wdata = 32'h66; expect_wr(5'd6, 32'h66);
        step();
        clear_inputs();
        check_val("post_rst_wen", 64'(reg_wen), 1);
        step(); step();
        check_val("queue_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire
